// File: rtl/card_game_ctrl.sv
// Game logic for the 8-card memory/matching game: button conditioning, cursor,
// reveal/compare sequencing, pair removal and win detection feeding the renderer.
module card_game_ctrl #(
    parameter int unsigned SHOW_CYCLES = 25000000,
    parameter logic [15:0] PAIR_MAP    = 16'hCDA4
) (
    input  logic       clk25MHz,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_sel,
    output logic [1:0] action0,
    output logic [1:0] action1,
    output logic [1:0] action2,
    output logic [1:0] action3,
    output logic [1:0] action4,
    output logic [1:0] action5,
    output logic [1:0] action6,
    output logic [1:0] action7,
    output logic       winscreen,
    output logic [2:0] match_count
);

    typedef enum logic [2:0] {
        PICK1   = 3'd0,
        PICK2   = 3'd1,
        HOLD    = 3'd2,
        RESOLVE = 3'd3,
        WIN     = 3'd4
    } state_t;

    localparam logic [24:0] HOLD_LAST = 25'(SHOW_CYCLES - 1);

    function automatic logic [1:0] pair_id(input logic [2:0] idx);
        logic [15:0] shifted;
        shifted = PAIR_MAP >> {idx, 1'b0};
        return shifted[1:0];
    endfunction

    logic        next_s1_r, next_s2_r, next_prev_r;
    logic        sel_s1_r, sel_s2_r, sel_prev_r;
    logic        next_ev_s, sel_ev_s;

    state_t      state_r;
    logic [2:0]  cursor_r;
    logic [2:0]  first_r;
    logic [2:0]  second_r;
    logic [7:0]  faceup_r;
    logic [7:0]  removed_r;
    logic [24:0] hold_cnt_r;
    logic [2:0]  match_cnt_r;

    logic [1:0]  action_nxt_s [8];
    logic [1:0]  action_r     [8];

    // Two-flop synchronizers plus previous-value registers for edge detection
    always_ff @(posedge clk25MHz or posedge rst) begin
        if (rst) begin
            next_s1_r   <= 1'b0;
            next_s2_r   <= 1'b0;
            next_prev_r <= 1'b0;
            sel_s1_r    <= 1'b0;
            sel_s2_r    <= 1'b0;
            sel_prev_r  <= 1'b0;
        end else begin
            next_s1_r   <= btn_next;
            next_s2_r   <= next_s1_r;
            next_prev_r <= next_s2_r;
            sel_s1_r    <= btn_sel;
            sel_s2_r    <= sel_s1_r;
            sel_prev_r  <= sel_s2_r;
        end
    end

    assign next_ev_s = next_s2_r & ~next_prev_r;
    assign sel_ev_s  = sel_s2_r & ~sel_prev_r;

    // Game state machine: cursor, reveals, hold timer and pair resolution
    always_ff @(posedge clk25MHz or posedge rst) begin
        if (rst) begin
            state_r     <= PICK1;
            cursor_r    <= 3'd0;
            first_r     <= 3'd0;
            second_r    <= 3'd0;
            faceup_r    <= 8'h00;
            removed_r   <= 8'h00;
            hold_cnt_r  <= 25'd0;
            match_cnt_r <= 3'd0;
        end else begin
            case (state_r)
                PICK1: begin
                    // sel wins over a coincident next; the next event is dropped
                    if (sel_ev_s) begin
                        if (!faceup_r[cursor_r] && !removed_r[cursor_r]) begin
                            faceup_r[cursor_r] <= 1'b1;
                            first_r            <= cursor_r;
                            state_r            <= PICK2;
                        end else begin
                            state_r <= PICK1;
                        end
                    end else if (next_ev_s) begin
                        cursor_r <= cursor_r + 3'd1;
                    end else begin
                        state_r <= PICK1;
                    end
                end
                PICK2: begin
                    if (sel_ev_s) begin
                        if (!faceup_r[cursor_r] && !removed_r[cursor_r] &&
                            (cursor_r != first_r)) begin
                            faceup_r[cursor_r] <= 1'b1;
                            second_r           <= cursor_r;
                            hold_cnt_r         <= 25'd0;
                            state_r            <= HOLD;
                        end else begin
                            state_r <= PICK2;
                        end
                    end else if (next_ev_s) begin
                        cursor_r <= cursor_r + 3'd1;
                    end else begin
                        state_r <= PICK2;
                    end
                end
                HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_r <= RESOLVE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + 25'd1;
                    end
                end
                RESOLVE: begin
                    faceup_r[first_r]  <= 1'b0;
                    faceup_r[second_r] <= 1'b0;
                    if (pair_id(first_r) == pair_id(second_r)) begin
                        removed_r[first_r]  <= 1'b1;
                        removed_r[second_r] <= 1'b1;
                        match_cnt_r         <= match_cnt_r + 3'd1;
                        state_r             <= (match_cnt_r == 3'd3) ? WIN : PICK1;
                    end else begin
                        state_r <= PICK1;
                    end
                end
                WIN: begin
                    state_r <= WIN;
                end
                default: begin
                    state_r <= PICK1;
                end
            endcase
        end
    end

    // Per-card renderer code: removed > face-up > cursor (only while picking)
    always_comb begin
        action_nxt_s = '{default: 2'b00};
        for (int i = 0; i < 8; i++) begin
            if (removed_r[i]) begin
                action_nxt_s[i] = 2'b11;
            end else if (faceup_r[i]) begin
                action_nxt_s[i] = 2'b10;
            end else if ((cursor_r == 3'(i)) && ((state_r == PICK1) || (state_r == PICK2))) begin
                action_nxt_s[i] = 2'b01;
            end else begin
                action_nxt_s[i] = 2'b00;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk25MHz or posedge rst) begin
        if (rst) begin
            action_r    <= '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
            winscreen   <= 1'b0;
            match_count <= 3'd0;
        end else begin
            action_r    <= action_nxt_s;
            winscreen   <= (state_r == WIN);
            match_count <= match_cnt_r;
        end
    end

    assign action0 = action_r[0];
    assign action1 = action_r[1];
    assign action2 = action_r[2];
    assign action3 = action_r[3];
    assign action4 = action_r[4];
    assign action5 = action_r[5];
    assign action6 = action_r[6];
    assign action7 = action_r[7];

endmodule

// File: tb/tb_card_game_ctrl.sv
// Bench for card_game_ctrl: directed game scenarios plus random button traffic,
// checked every cycle against a behavioural game model.
module tb_card_game_ctrl;

    localparam int S = 8;

    logic       clk25MHz = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_sel = 1'b0;
    logic [1:0] action0, action1, action2, action3, action4, action5, action6, action7;
    logic       winscreen;
    logic [2:0] match_count;
    logic [1:0] acts [8];

    int checks = 0;
    int errors = 0;

    card_game_ctrl #(.SHOW_CYCLES(S), .PAIR_MAP(16'hCDA4)) dut (
        .clk25MHz(clk25MHz), .rst(rst), .btn_next(btn_next), .btn_sel(btn_sel),
        .action0(action0), .action1(action1), .action2(action2), .action3(action3),
        .action4(action4), .action5(action5), .action6(action6), .action7(action7),
        .winscreen(winscreen), .match_count(match_count)
    );

    always #5 clk25MHz = ~clk25MHz;

    assign acts[0] = action0; assign acts[1] = action1;
    assign acts[2] = action2; assign acts[3] = action3;
    assign acts[4] = action4; assign acts[5] = action5;
    assign acts[6] = action6; assign acts[7] = action7;

    // ---------------- behavioural model ----------------
    localparam int P1 = 0, P2 = 1, PH = 2, PR = 3, PW = 4;
    int   partner [8] = '{6, 4, 3, 2, 1, 7, 0, 5};
    int   m_phase, m_cur, m_first, m_second, m_left, m_cnt;
    bit   m_up [8];
    bit   m_rm [8];
    bit [2:0] nh, sh;
    logic [1:0] e_act [8];
    int   e_win, e_cnt;

    task automatic model_reset();
        m_phase = P1; m_cur = 0; m_first = 0; m_second = 0; m_left = 0; m_cnt = 0;
        nh = 3'b000; sh = 3'b000;
        for (int i = 0; i < 8; i++) begin
            m_up[i] = 1'b0; m_rm[i] = 1'b0;
            e_act[i] = (i == 0) ? 2'b01 : 2'b00;
        end
        e_win = 0; e_cnt = 0;
    endtask

    task automatic model_step();
        bit ne, se;
        for (int i = 0; i < 8; i++) begin
            if (m_rm[i]) e_act[i] = 2'b11;
            else if (m_up[i]) e_act[i] = 2'b10;
            else if (m_cur == i && (m_phase == P1 || m_phase == P2)) e_act[i] = 2'b01;
            else e_act[i] = 2'b00;
        end
        e_win = (m_phase == PW) ? 1 : 0;
        e_cnt = m_cnt;
        // a press is seen two samples after the raw level rises
        ne = nh[1] & ~nh[2];
        se = sh[1] & ~sh[2];
        nh = {nh[1:0], btn_next};
        sh = {sh[1:0], btn_sel};
        if (m_phase == P1 || m_phase == P2) begin
            if (se) begin
                if (!m_up[m_cur] && !m_rm[m_cur]) begin
                    m_up[m_cur] = 1'b1;
                    if (m_phase == P1) begin
                        m_first = m_cur; m_phase = P2;
                    end else begin
                        m_second = m_cur; m_left = S; m_phase = PH;
                    end
                end
            end else if (ne) begin
                m_cur = (m_cur + 1) % 8;
            end
        end else if (m_phase == PH) begin
            m_left--;
            if (m_left == 0) m_phase = PR;
        end else if (m_phase == PR) begin
            m_up[m_first] = 1'b0; m_up[m_second] = 1'b0;
            if (partner[m_first] == m_second) begin
                m_rm[m_first] = 1'b1; m_rm[m_second] = 1'b1; m_cnt++;
            end
            m_phase = (m_cnt == 4) ? PW : P1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk25MHz);
            if (rst) model_reset();
            else model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk25MHz);
            for (int i = 0; i < 8; i++) check($sformatf("model action%0d", i), acts[i], e_act[i]);
            check("model winscreen", winscreen, e_win);
            check("model match_count", match_count, e_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk25MHz);
            #2;
        end
    endtask

    task automatic press(input logic n, input logic s);
        btn_next = n; btn_sel = s;
        step(2);
        btn_next = 1'b0; btn_sel = 1'b0;
        step(4);
    endtask

    task automatic nexts(input int n);
        repeat (n) press(1'b1, 1'b0);
    endtask

    // Hold sel down and count how many sampled cycles card idx stays face-up
    task automatic reveal_measure(input int idx, output int dur);
        int w = 0;
        dur = 0;
        btn_sel = 1'b1;
        while (acts[idx] != 2'b10 && w < 10) begin step(1); w++; end
        while (acts[idx] == 2'b10 && dur < 40) begin dur++; step(1); end
        btn_sel = 1'b0;
        step(2);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " action0"}, action0, 1);
        for (int i = 1; i < 8; i++) check($sformatf("%s action%0d", tag, i), acts[i], 0);
        check({tag, " winscreen"}, winscreen, 0);
        check({tag, " match_count"}, match_count, 0);
    endtask

    int dur;

    initial begin
        rst = 1'b1;
        step(3);
        check_reset_values("reset");
        rst = 1'b0;
        step(2);

        // cursor movement and wrap
        nexts(3);
        check("cursor3 action3", action3, 1);
        check("cursor3 action0", action0, 0);
        nexts(5);
        check("wrap action0", action0, 1);

        // matching pair 0/6
        press(1'b0, 1'b1);
        check("first reveal action0", action0, 2);
        nexts(6);
        reveal_measure(6, dur);
        check("match reveal duration", dur, S + 1);
        check("match action0", action0, 3);
        check("match action6", action6, 3);
        check("match count1", match_count, 1);

        // mismatch 1/2
        nexts(3);
        press(1'b0, 1'b1);
        nexts(1);
        reveal_measure(2, dur);
        check("mismatch reveal duration", dur, S + 1);
        check("mismatch action1", action1, 0);
        check("mismatch action2 cursor", action2, 1);
        check("mismatch count", match_count, 1);

        // simultaneous next+sel on card 2: sel wins
        press(1'b1, 1'b1);
        check("both action2", action2, 2);
        check("both action3", action3, 0);
        // reselect same card and select removed card: ignored
        press(1'b0, 1'b1);
        check("resel action2", action2, 2);
        nexts(1);
        check("pick2 cursor action3", action3, 1);
        nexts(3);
        press(1'b0, 1'b1);
        check("removed sel action6", action6, 3);
        check("removed sel action2", action2, 2);
        check("removed sel action5", action5, 0);
        nexts(5);
        // reveal card 3, then press both buttons during HOLD
        press(1'b0, 1'b1);
        press(1'b1, 1'b1);
        step(3);
        check("pair23 action2", action2, 3);
        check("pair23 action3", action3, 3);
        check("pair23 count", match_count, 2);
        nexts(1);
        check("hold ignored next action4", action4, 1);

        // finish the game
        press(1'b0, 1'b1);
        nexts(5);
        press(1'b0, 1'b1);
        step(12);
        check("pair14 count", match_count, 3);
        nexts(4);
        press(1'b0, 1'b1);
        nexts(2);
        press(1'b0, 1'b1);
        step(12);
        check("win winscreen", winscreen, 1);
        check("win count", match_count, 4);
        for (int i = 0; i < 8; i++) check($sformatf("win action%0d", i), acts[i], 3);
        press(1'b1, 1'b1);
        press(1'b1, 1'b0);
        check("win sticky winscreen", winscreen, 1);
        check("win sticky count", match_count, 4);

        // fresh game, reset mid-HOLD
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        press(1'b0, 1'b1);
        nexts(1);
        press(1'b0, 1'b1);
        step(1);
        check("prereset action1", action1, 2);
        rst = 1'b1;
        #1;
        check_reset_values("midhold reset");
        step(2);
        rst = 1'b0;
        step(2);

        // random traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) btn_next = ~btn_next;
            if ($urandom_range(0, 3) == 0) btn_sel = ~btn_sel;
            rst = ($urandom_range(0, 999) == 0);
            step(1);
        end
        rst = 1'b0;
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
